// File: rtl/id_decode_stage.sv
// RISC-V decode stage: registered decode with a skid entry, RV32I/RV64I.
// Define RV_M_EXT_EN to decode the M extension (MUL..REMU, and *W forms on RV64).
module id_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd_addr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] immediate,
    output logic [4:0]      alu_op,
    output logic            alu_src_b,
    output logic            reg_write_en,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic            branch_en,
    output logic            jump_en,
    output logic [2:0]      mem_size,
    output logic [1:0]      mem_to_reg,
    output logic            word_op,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);
`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_COPY = 5'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic            alu_src_b;
        logic            reg_write_en;
        logic            mem_read_en;
        logic            mem_write_en;
        logic            branch_en;
        logic            jump_en;
        logic [2:0]      mem_size;
        logic [1:0]      mem_to_reg;
        logic            word_op;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [4:0] base_op(input logic [2:0] f3,
                                           input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic sh_ok_l, sh_ok_r;
    logic f7_zero, f7_alt, f7_mul;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);
    assign f7_mul  = (f7 == 7'b0000001);

    assign imm_i = sext({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_s = sext({{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]});
    assign imm_b = sext({{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0});
    assign imm_u = sext({in_instr[31:12], 12'b0});
    assign imm_j = sext({{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0});

    // RV64 shamt is 6 bits, so bit 25 belongs to the shift amount there
    assign sh_ok_l = RV64 ? (in_instr[31:26] == 6'b0)
                          : (in_instr[31:25] == 7'b0);
    assign sh_ok_r = RV64 ? ({in_instr[31], in_instr[29:26]} == 5'b0)
                          : ({in_instr[31], in_instr[29:25]} == 6'b0);

    dec_t dec;
    logic ok;

    always_comb begin
        dec = '0;
        ok  = 1'b1;
        case (opcode)
            OP_LUI: begin
                dec.imm          = imm_u;
                dec.alu_op       = ALU_COPY;
                dec.alu_src_b    = 1'b1;
                dec.reg_write_en = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm          = imm_u;
                dec.alu_src_b    = 1'b1;
                dec.reg_write_en = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec.imm          = (opcode == OP_JAL) ? imm_j : imm_i;
                dec.alu_src_b    = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.jump_en      = 1'b1;
                dec.mem_to_reg   = 2'b10;
                ok = (opcode == OP_JAL) || (f3 == 3'b000);
            end
            OP_BRANCH: begin
                dec.imm       = imm_b;
                dec.branch_en = 1'b1;
                dec.alu_op    = !f3[2] ? ALU_SUB
                              : (f3[1] ? ALU_SLTU : ALU_SLT);
                ok = (f3[2:1] != 2'b01);
            end
            OP_LOAD: begin
                dec.imm          = imm_i;
                dec.alu_src_b    = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.mem_read_en  = 1'b1;
                dec.mem_to_reg   = 2'b01;
                dec.mem_size     = f3;
                ok = (f3 != 3'b111) &&
                     (RV64 || (f3 != 3'b011 && f3 != 3'b110));
            end
            OP_STORE: begin
                dec.imm          = imm_s;
                dec.alu_src_b    = 1'b1;
                dec.mem_write_en = 1'b1;
                dec.mem_size     = f3;
                ok = RV64 ? (f3 <= 3'b011) : (f3 <= 3'b010);
            end
            OP_IMM, OP_IMM32: begin
                dec.imm          = imm_i;
                dec.alu_src_b    = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.alu_op  = base_op(f3, f3 == 3'b101 && in_instr[30]);
                dec.word_op = (opcode == OP_IMM32);
                if (opcode == OP_IMM) begin
                    if (f3 == 3'b001)
                        ok = sh_ok_l;
                    else if (f3 == 3'b101)
                        ok = sh_ok_r;
                end else begin
                    ok = RV64 && ((f3 == 3'b000) ||
                         (f3 == 3'b001 && f7_zero) ||
                         (f3 == 3'b101 && (f7_zero || f7_alt)));
                end
            end
            OP_OP: begin
                dec.reg_write_en = 1'b1;
                if (f7_zero)
                    dec.alu_op = base_op(f3, 1'b0);
                else if (f7_alt && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alu_op = base_op(f3, 1'b1);
                else if (f7_mul && M_EN)
                    dec.alu_op = 5'd16 + {2'b00, f3};
                else
                    ok = 1'b0;
            end
            OP_OP32: begin
                dec.reg_write_en = 1'b1;
                dec.word_op      = 1'b1;
                dec.alu_op = f7_mul ? 5'd16 + {2'b00, f3}
                                    : base_op(f3, f7_alt);
                ok = RV64 && (
                     (f7_zero && (f3 == 3'b000 || f3 == 3'b001 ||
                                  f3 == 3'b101)) ||
                     (f7_alt && (f3 == 3'b000 || f3 == 3'b101)) ||
                     (f7_mul && M_EN && (f3 == 3'b000 || f3[2])));
            end
            default: ok = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11)
            ok = 1'b0;
        if (!ok) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc  = in_pc;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
    end

    dec_t main_q, skid_q;
    logic main_valid, skid_valid;
    logic accept;

    assign in_ready = rst_n && !skid_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept)
                    main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid    = main_valid;
    assign out_pc       = main_q.pc;
    assign rd_addr      = main_q.rd;
    assign rs1_addr     = main_q.rs1;
    assign rs2_addr     = main_q.rs2;
    assign immediate    = main_q.imm;
    assign alu_op       = main_q.alu_op;
    assign alu_src_b    = main_q.alu_src_b;
    assign reg_write_en = main_q.reg_write_en;
    assign mem_read_en  = main_q.mem_read_en;
    assign mem_write_en = main_q.mem_write_en;
    assign branch_en    = main_q.branch_en;
    assign jump_en      = main_q.jump_en;
    assign mem_size     = main_q.mem_size;
    assign mem_to_reg   = main_q.mem_to_reg;
    assign word_op      = main_q.word_op;
    assign illegal      = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: RV32 and RV64 instances
// share one stimulus stream and are checked against hand-computed values.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, immediate;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr, alu_op;
    logic        alu_src_b, reg_write_en, mem_read_en, mem_write_en;
    logic        branch_en, jump_en, word_op, illegal;
    logic [2:0]  mem_size;
    logic [1:0]  mem_to_reg;

    logic        in_ready_64, out_valid_64;
    logic [63:0] out_pc_64, immediate_64;
    logic [4:0]  rd_64, rs1_64, rs2_64, alu_op_64;
    logic        alu_src_b_64, reg_write_en_64, mem_read_en_64;
    logic        mem_write_en_64, branch_en_64, jump_en_64;
    logic        word_op_64, illegal_64;
    logic [2:0]  mem_size_64;
    logic [1:0]  mem_to_reg_64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    assign in_pc64 = {32'b0, in_pc};

    id_decode_stage #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd_addr(rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .immediate(immediate), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .reg_write_en(reg_write_en),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .branch_en(branch_en), .jump_en(jump_en),
        .mem_size(mem_size), .mem_to_reg(mem_to_reg),
        .word_op(word_op), .illegal(illegal)
    );

    id_decode_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid_64), .out_ready(out_ready),
        .out_pc(out_pc_64), .rd_addr(rd_64),
        .rs1_addr(rs1_64), .rs2_addr(rs2_64),
        .immediate(immediate_64), .alu_op(alu_op_64),
        .alu_src_b(alu_src_b_64), .reg_write_en(reg_write_en_64),
        .mem_read_en(mem_read_en_64), .mem_write_en(mem_write_en_64),
        .branch_en(branch_en_64), .jump_en(jump_en_64),
        .mem_size(mem_size_64), .mem_to_reg(mem_to_reg_64),
        .word_op(word_op_64), .illegal(illegal_64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_instr = '0; in_pc = '0;

        // reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
        end
        check("rst_imm", immediate, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rwe", reg_write_en, 0);
        check("rst_illegal", illegal, 0);
        check("rst_out_valid_64", out_valid_64, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // addi x1,x0,-1
        out_ready = 1'b1;
        offer(32'hFFF00093, 32'h100);
        tick();
        in_valid = 1'b0;
        check("addi_valid", out_valid, 1);
        check("addi_pc", out_pc, 32'h100);
        check("addi_rd", rd_addr, 1);
        check("addi_rs1", rs1_addr, 0);
        check("addi_imm", immediate, 32'hFFFFFFFF);
        check("addi_alu", alu_op, 0);
        check("addi_srcb", alu_src_b, 1);
        check("addi_rwe", reg_write_en, 1);
        check("addi_imm_64", immediate_64, 64'hFFFFFFFFFFFFFFFF);
        tick();
        check("drain_valid", out_valid, 0);

        // backpressure: sub then sw, third offer refused
        out_ready = 1'b0;
        offer(32'h40208133, 32'h200);
        tick();
        check("sub_valid", out_valid, 1);
        check("sub_alu", alu_op, 1);
        check("sub_rs2", rs2_addr, 2);
        check("sub_in_ready", in_ready, 1);
        offer(32'h00112223, 32'h204);
        tick();
        check("stall_alu", alu_op, 1);
        check("stall_rd", rd_addr, 2);
        check("stall_pc", out_pc, 32'h200);
        check("stall_in_ready", in_ready, 0);
        offer(32'hFFF00093, 32'h300);
        tick();
        check("refuse_alu", alu_op, 1);
        check("refuse_pc", out_pc, 32'h200);
        check("refuse_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("sw_valid", out_valid, 1);
        check("sw_pc", out_pc, 32'h204);
        check("sw_alu", alu_op, 0);
        check("sw_imm", immediate, 4);
        check("sw_mwe", mem_write_en, 1);
        check("sw_size", mem_size, 3'b010);
        check("sw_rwe", reg_write_en, 0);
        check("sw_in_ready", in_ready, 1);
        tick();
        check("after_sw_valid", out_valid, 0);

        // illegal encodings
        offer(32'h00000000, 32'h400);
        tick();
        check("ill0_valid", out_valid, 1);
        check("ill0_illegal", illegal, 1);
        check("ill0_en", {reg_write_en, mem_read_en, mem_write_en,
                          branch_en, jump_en}, 0);
        check("ill0_imm", immediate, 0);
        offer(32'hFFFFFFFF, 32'h404);
        tick();
        check("ill1_valid", out_valid, 1);
        check("ill1_illegal", illegal, 1);
        check("ill1_en", {reg_write_en, mem_read_en, mem_write_en,
                          branch_en, jump_en}, 0);
        check("ill1_imm_alu", {immediate, alu_op}, 0);

        // streamed decode vectors
        offer(32'h0020D463, 32'h500);
        tick();
        check("bge_alu", alu_op, 3);
        check("bge_br", branch_en, 1);
        check("bge_imm", immediate, 8);
        check("bge_rwe_ill", {reg_write_en, illegal}, 0);
        offer(32'h4030D093, 32'h504);
        tick();
        check("srai_alu", alu_op, 7);
        check("srai_imm", immediate, 32'h403);
        check("srai_ill", illegal, 0);
        check("srai_ill_64", illegal_64, 0);
        offer(32'h02009093, 32'h508);
        tick();
        check("slli32_ill", illegal, 1);
        check("slli32_ill_64", illegal_64, 0);
        check("slli32_alu_64", alu_op_64, 2);
        offer(32'h800002B7, 32'h50C);
        tick();
        check("lui_alu", alu_op, 10);
        check("lui_imm", immediate, 32'h80000000);
        check("lui_imm_64", immediate_64, 64'hFFFFFFFF80000000);
        offer(32'h0000B003, 32'h510);
        tick();
        check("ld_ill", illegal, 1);
        check("ld_ill_64", illegal_64, 0);
        check("ld_mre_64", mem_read_en_64, 1);
        check("ld_size_64", mem_size_64, 3'b011);
        check("ld_m2r_64", mem_to_reg_64, 2'b01);
        offer(32'h02208033, 32'h514);
        tick();
`ifdef RV_M_EXT_EN
        check("mul_ill", illegal, 0);
        check("mul_alu", alu_op, 16);
`else
        check("mul_ill", illegal, 1);
        check("mul_alu", alu_op, 0);
`endif
        offer(32'h0010809B, 32'h518);
        tick();
        check("addiw_ill", illegal, 1);
        check("addiw_word", word_op, 0);
        check("addiw_ill_64", illegal_64, 0);
        check("addiw_word_64", word_op_64, 1);
        check("addiw_imm_64", immediate_64, 1);
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", out_valid, 0);

        // flush with both entries full and an offer pending
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h600);
        tick();
        offer(32'h40208133, 32'h604);
        tick();
        check("full_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        flush = 1'b1;
        offer(32'h00112223, 32'h608);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("flush_drop", out_valid, 0);
        check("flush_drop_64", out_valid_64, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
